// File: rtl/led_uart_reporter.sv
// Logs every change of the ALU's LED byte as an 8N1 UART frame.
// Changes are queued in a small FIFO and drained by a single baud-timed TX FSM.
module led_uart_reporter #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int CW           = 3
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [7:0]    iLed,
    input  logic          iEnable,
    output logic          oTx,
    output logic          oBusy,
    output logic          oOverflow,
    output logic [CW-1:0] oFifoCount
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    state_t          state_next;
    logic [BW-1:0]   baud;
    logic [BW-1:0]   baud_next;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_next;
    logic [7:0]      shift;
    logic [7:0]      shift_next;
    logic            tx_next;
    logic            baud_done;

    logic [7:0]      last_led;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            change;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign change     = iEnable && (iLed != last_led);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign pop        = (state == IDLE) && (count != '0);
    assign push       = change && (!full || pop);
    assign drop       = change && full && !pop;
    assign oFifoCount = count;
    assign baud_done  = (baud == BW'(CLKS_PER_BIT - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_led  <= 8'h00;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (change) begin
                last_led <= iLed;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                oOverflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[wr_ptr] <= iLed;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= 8'h00;
            oTx     <= 1'b1;
            oBusy   <= 1'b0;
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            oTx     <= tx_next;
            oBusy   <= (state_next != IDLE);
        end
    end

    // The line level is precomputed from the next state so oTx is a clean flop output.
    always_comb begin
        state_next   = state;
        baud_next    = baud;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = 1'b1;

        case (state)
            IDLE: begin
                baud_next = '0;
                if (pop) begin
                    shift_next = mem[rd_ptr];
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_next    = '0;
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud + BW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_led_uart_reporter.sv
// Self-checking bench for led_uart_reporter: a frame-position model predicts
// the serial line, busy, overflow and FIFO count every cycle.
module tb_led_uart_reporter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          Clock;
    logic          Reset;
    logic [7:0]    iLed;
    logic          iEnable;
    logic          oTx;
    logic          oBusy;
    logic          oOverflow;
    logic [CW-1:0] oFifoCount;

    int checks   = 0;
    int failures = 0;

    logic [7:0] m_q[$];
    logic [7:0] m_last = 8'h00;
    logic [7:0] m_byte = 8'h00;
    int         m_pos  = -1;
    logic       m_ovf  = 1'b0;

    led_uart_reporter #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .CW          (CW)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iLed      (iLed),
        .iEnable   (iEnable),
        .oTx       (oTx),
        .oBusy     (oBusy),
        .oOverflow (oOverflow),
        .oFifoCount(oFifoCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: m_pos is the cycle index inside the current frame, -1 when idle.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_q.delete();
            m_last = 8'h00;
            m_byte = 8'h00;
            m_pos  = -1;
            m_ovf  = 1'b0;
        end else begin
            if (m_pos < 0) begin
                if (m_q.size() > 0) begin
                    m_byte = m_q.pop_front();
                    m_pos  = 0;
                end
            end else begin
                m_pos++;
                if (m_pos == 10 * CPB) m_pos = -1;
            end
            if (iEnable && iLed != m_last) begin
                m_last = iLed;
                if (m_q.size() < DEPTH) m_q.push_back(iLed);
                else m_ovf = 1'b1;
            end
        end
    end

    function automatic logic model_tx();
        int idx;
        if (m_pos < 0) return 1'b1;
        idx = m_pos / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_byte[idx-1];
    endfunction

    always @(negedge Clock) begin
        check_output("tx", 32'(oTx), 32'(model_tx()));
        check_output("busy", 32'(oBusy), 32'(m_pos >= 0));
        check_output("overflow", 32'(oOverflow), 32'(m_ovf));
        check_output("fifo_count", 32'(oFifoCount), 32'(m_q.size()));
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] led, input logic en);
        iLed    = led;
        iEnable = en;
        step(1);
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!oBusy && oFifoCount == '0) begin
                done = 1'b1;
                break;
            end
            step(1);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL wait_idle timeout: busy=%0b count=%0d required busy=0 count=0", oBusy, oFifoCount);
        end
    endtask

    initial begin
        Reset   = 1'b1;
        iLed    = 8'h00;
        iEnable = 1'b1;
        step(3);
        Reset = 1'b0;
        check_output("reset_tx", 32'(oTx), 32'h1);
        check_output("reset_busy", 32'(oBusy), 32'h0);
        check_output("reset_count", 32'(oFifoCount), 32'h0);

        step(100);
        check_output("quiet_tx", 32'(oTx), 32'h1);
        check_output("quiet_busy", 32'(oBusy), 32'h0);

        // Single A5 frame with hand-timed bit positions
        step(9);
        apply_stimulus(8'hA5, 1'b1);
        check_output("a5_pushed_count", 32'(oFifoCount), 32'h1);
        check_output("a5_pushed_tx", 32'(oTx), 32'h1);
        step(1);
        check_output("a5_start_tx", 32'(oTx), 32'h0);
        check_output("a5_start_busy", 32'(oBusy), 32'h1);
        check_output("a5_popped_count", 32'(oFifoCount), 32'h0);
        step(4);
        check_output("a5_bit0", 32'(oTx), 32'h1);
        step(4);
        check_output("a5_bit1", 32'(oTx), 32'h0);
        step(31);
        check_output("a5_stop_tx", 32'(oTx), 32'h1);
        check_output("a5_stop_busy", 32'(oBusy), 32'h1);
        step(1);
        check_output("a5_done_busy", 32'(oBusy), 32'h0);

        // Burst of five: first pops immediately, four queue up
        for (int v = 1; v <= 5; v++) apply_stimulus(8'(v), 1'b1);
        check_output("burst_count", 32'(oFifoCount), 32'h4);
        check_output("burst_ovf", 32'(oOverflow), 32'h0);
        wait_idle(400);

        // Six changes during a frame: four queued, two dropped
        apply_stimulus(8'h10, 1'b1);
        step(1);
        for (int v = 8'h11; v <= 8'h16; v++) apply_stimulus(8'(v), 1'b1);
        check_output("ovf_count", 32'(oFifoCount), 32'h4);
        check_output("ovf_flag", 32'(oOverflow), 32'h1);
        wait_idle(400);
        check_output("ovf_sticky", 32'(oOverflow), 32'h1);

        // Reset in the middle of an FF frame with two entries queued
        apply_stimulus(8'hFF, 1'b1);
        step(1);
        apply_stimulus(8'h01, 1'b1);
        apply_stimulus(8'h02, 1'b1);
        check_output("pre_reset_count", 32'(oFifoCount), 32'h2);
        step(14);
        check_output("pre_reset_busy", 32'(oBusy), 32'h1);
        Reset = 1'b1;
        iLed  = 8'h00;
        #1;
        check_output("midreset_tx", 32'(oTx), 32'h1);
        check_output("midreset_count", 32'(oFifoCount), 32'h0);
        check_output("midreset_busy", 32'(oBusy), 32'h0);
        check_output("midreset_ovf", 32'(oOverflow), 32'h0);
        step(2);
        Reset = 1'b0;
        step(20);
        check_output("post_reset_busy", 32'(oBusy), 32'h0);
        apply_stimulus(8'h3C, 1'b1);
        check_output("3c_count", 32'(oFifoCount), 32'h1);
        wait_idle(200);

        // Changes while disabled are ignored until re-enable
        apply_stimulus(8'h77, 1'b0);
        step(20);
        check_output("disabled_busy", 32'(oBusy), 32'h0);
        check_output("disabled_count", 32'(oFifoCount), 32'h0);
        apply_stimulus(8'h77, 1'b1);
        check_output("reenable_count", 32'(oFifoCount), 32'h1);
        wait_idle(200);
        step(60);
        check_output("single_77_busy", 32'(oBusy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
